// File: rtl/sbc_serial_sub.sv
// 6502 SBC subtractor: one nibble per cycle through a 5-bit borrow chain, start/done handshake.
// Define DECIMAL_EN to build NMOS-style BCD correction; otherwise the decimal input is ignored.
module sbc_serial_sub (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  input  logic       decimal,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       c_out,
  output logic       v_out,
  output logic       n_out,
  output logic       z_out
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t     state, state_next;
  logic [7:0] a_r, b_r;
  logic       cin_r;
  logic       h_r;
  logic [3:0] lo_bin_r;
  logic [3:0] lo_out_r;
  logic       dec_r;

  logic       capture;
  logic       finish;
  logic [4:0] lo_sum, hi_sum;
  logic [3:0] lo_fix, hi_fix;
  logic [7:0] bin;

  // NOTE: two-process FSM; the state register alone is clocked, so every
  // next-state decision lives in the always_comb below with defaults first.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (start) begin
        capture    = 1'b1;
        state_next = LO;
      end
      LO:   state_next = HI;
      HI: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Low nibble uses the captured carry; high nibble consumes the stored half-carry.
  assign lo_sum = {1'b0, a_r[3:0]} + {1'b0, ~b_r[3:0]} + {4'b0, cin_r};
  assign hi_sum = {1'b0, a_r[7:4]} + {1'b0, ~b_r[7:4]} + {4'b0, h_r};
  assign bin    = {hi_sum[3:0], lo_bin_r};

`ifdef DECIMAL_EN
  assign lo_fix = (dec_r && !lo_sum[4]) ? lo_sum[3:0] - 4'd6 : lo_sum[3:0];
  assign hi_fix = (dec_r && !hi_sum[4]) ? hi_sum[3:0] - 4'd6 : hi_sum[3:0];
`else
  logic unused_decimal;
  assign unused_decimal = dec_r;
  assign lo_fix = lo_sum[3:0];
  assign hi_fix = hi_sum[3:0];
`endif

  // NOTE: every register here is cleared by the synchronous reset; they are
  // individual flops, not a memory, so a reset costs nothing and keeps X out.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= 8'h00;
      b_r      <= 8'h00;
      cin_r    <= 1'b0;
      dec_r    <= 1'b0;
      h_r      <= 1'b0;
      lo_bin_r <= 4'h0;
      lo_out_r <= 4'h0;
      done     <= 1'b0;
      result   <= 8'h00;
      c_out    <= 1'b0;
      v_out    <= 1'b0;
      n_out    <= 1'b0;
      z_out    <= 1'b0;
    end else begin
      done <= finish;
      if (capture) begin
        a_r   <= a;
        b_r   <= b;
        cin_r <= carry_in;
        dec_r <= decimal;
      end
      if (state == LO) begin
        h_r      <= lo_sum[4];
        lo_bin_r <= lo_sum[3:0];
        lo_out_r <= lo_fix;
      end
      // N, Z and V follow the binary difference even when BCD-corrected.
      if (finish) begin
        result <= {hi_fix, lo_out_r};
        c_out  <= hi_sum[4];
        n_out  <= bin[7];
        z_out  <= (bin == 8'h00);
        v_out  <= (a_r[7] ^ b_r[7]) & (a_r[7] ^ bin[7]);
      end
    end
  end

endmodule

// File: doc/sbc_serial_sub.md
# sbc_serial_sub

Multi-cycle 8-bit subtractor implementing 6502 SBC semantics (A − B − !C) with optional NMOS-style decimal correction. It is the subtract-direction counterpart to the carry-chain adder path. It computes one nibble per cycle through a 5-bit borrow chain, which shortens the critical path of the CPU ALU. The CPU core issues operations with a start/done handshake and reads the registered result and flags.

## Interface
Parameters:
- none; datapath fixed at 8 bits, two 4-bit nibble steps.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- start  in  1  request; sampled only when idle.
- a  in  8  minuend (accumulator).
- b  in  8  subtrahend (memory operand).
- carry_in  in  1  6502 carry flag; 1 = no borrow.
- decimal  in  1  D flag; selects BCD correction (see Configuration).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle onward.
- result  out  8  difference.
- c_out  out  1  carry (1 = no borrow).
- v_out  out  1  signed overflow.
- n_out  out  1  bit 7 of the binary difference.
- z_out  out  1  binary difference == 0.

## Operation
- States: IDLE, LO, HI. busy = (state != IDLE).
- IDLE: if start, capture a, b, carry_in and decimal into internal registers; go to LO. Otherwise hold.
- LO: lo = {0,a[3:0]} + {0,~b[3:0]} + carry_in (5 bits); h = lo[4].
  - If decimal and !h, the stored low nibble is lo[3:0] − 6 mod 16; otherwise it is lo[3:0].
  - Store h; go to HI.
- HI: hi = {0,a[7:4]} + {0,~b[7:4]} + h (5 bits); c = hi[4].
  - If decimal and !c, the high nibble is hi[3:0] − 6 mod 16; otherwise it is hi[3:0].
  - bin = {hi[3:0], lo[3:0]}.
  - Register result, c_out = c, n_out = bin[7], z_out = (bin == 0), v_out = (a^b) & (a^bin) bit 7.
  - Pulse done; go to IDLE.
- Flag rules (NMOS behaviour): N, Z and V always come from the binary difference, even in decimal mode. C is identical in both modes.
- Invalid BCD operands are not checked; the nibble rules above apply unchanged.
- start while busy is ignored, not queued.
- Operands are captured once at start. Input changes during LO/HI have no effect.
- result and flags hold their last value until the next completion.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, result = 0x00, c_out = v_out = n_out = z_out = 0.
- start high in cycle 0 (idle): busy is high in cycles 1–2; done and new outputs appear in cycle 3; busy is 0 in cycle 3.
- Latency from start to done is 3 cycles. Throughput is one operation per 3 cycles.
- A start in the done cycle is accepted, giving back-to-back operation.
- reset in any state takes effect at the next edge: the operation is abandoned, done does not pulse, and outputs return to reset values.
- reset and start in the same cycle: reset wins.

## Configuration
- DECIMAL_EN defined: the decimal input is honoured as described in Operation.
- DECIMAL_EN undefined: the decimal input is ignored and no correction logic is built. The block behaves as a binary-only subtractor, matching the 2A03 CPU, which has no decimal mode. Flags are unchanged.

## Test plan
- Binary overflow: a=0x50, b=0xB0, carry_in=1, decimal=0 -> result=0xA0, C=0, V=1, N=1, Z=0; done pulses exactly 3 cycles after start.
- Binary zero: a=0x40, b=0x40, carry_in=1 -> result=0x00, C=1, Z=1, V=0, N=0.
- Decimal borrow (DECIMAL_EN): a=0x12, b=0x21, carry_in=1, decimal=1 -> result=0x91, C=0, N=1, Z=0, V=0. Same operands without DECIMAL_EN -> result=0xF1.
- Decimal wrap (DECIMAL_EN): a=0x00, b=0x01, carry_in=1, decimal=1 -> result=0x99, C=0. a=0x46, b=0x12, carry_in=1 -> result=0x34, C=1.
- Handshake: pulse start again in cycles 1 and 2 with different operands -> ignored; single done; result from first operands. Start in the done cycle -> second done 3 cycles later.
- Reset mid-op: assert reset in cycle 2 -> no done; busy=0 and all outputs 0 in the next cycle; a subsequent start completes normally.
